// File: rtl/seq_det_pkg.sv
// Shared constants and types for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam logic [3:0] DEF_PATTERN = 4'b1011;

    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } overlap_mode_e;

    // Width of the fill counter, which saturates at pattern_w-1.
    function automatic int fill_w(input int pattern_w);
        return $clog2(pattern_w);
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt = cnt_q;
    assign sat = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with Mealy/registered match and saturating count.
// Optional SEQDET_MASK_EN adds a per-bit don't-care mask loaded with the pattern.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = DEF_PATTERN,
    parameter int                   CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 pat_load,
    input  logic [PATTERN_W-1:0] pat_in,
`ifdef SEQDET_MASK_EN
    input  logic [PATTERN_W-1:0] mask_in,
`endif
    input  logic                 overlap_en,
    input  logic                 cnt_clr,
    output logic                 match,
    output logic                 match_q,
    output logic [CNT_W-1:0]     match_cnt,
    output logic                 cnt_sat
);

    localparam int                FILL_W   = fill_w(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W - 1);

    // Stream beat: in_bit is consumed on every cycle with in_valid=1 and pat_load=0;
    // there is no back-pressure. pat_load wins over in_valid and drops that cycle's bit.
    logic [PATTERN_W-1:0] pattern_q, pattern_d;
    logic [PATTERN_W-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [PATTERN_W-1:0] window;
    logic                 accept;
    logic                 full;
    logic                 hit;
    overlap_mode_e        mode;

`ifdef SEQDET_MASK_EN
    logic [PATTERN_W-1:0] mask_q, mask_d;
`endif

    always_comb begin
        window    = {hist_q, in_bit};
        accept    = in_valid & ~pat_load;
        full      = (fill_q == FILL_MAX);
        mode      = overlap_mode_e'(overlap_en);
`ifdef SEQDET_MASK_EN
        hit       = (((window ^ pattern_q) & mask_q) == '0);
        mask_d    = mask_q;
`else
        hit       = (window == pattern_q);
`endif
        match     = rst_n & accept & full & hit;
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;

        if (pat_load) begin
            pattern_d = pat_in;
            hist_d    = '0;
            fill_d    = '0;
`ifdef SEQDET_MASK_EN
            mask_d    = mask_in;
`endif
        end else if (in_valid) begin
            if (match && (mode == NON_OVERLAP)) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PATTERN_W-2:0];
                fill_d = full ? fill_q : fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_q <= PATTERN;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
`ifdef SEQDET_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match;
`ifdef SEQDET_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match),
        .clr   (cnt_clr),
        .cnt   (match_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed scoreboard bench: drivers push expected match per beat, a negedge monitor pops and compares.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0;
    logic       overlap_en = 1'b1;
    logic       cnt_clr = 1'b0;
    logic       match, match_q, cnt_sat;
    logic [7:0] match_cnt;
    logic       match2, match_q2, sat2;
    logic [1:0] cnt2;
`ifdef SEQDET_MASK_EN
    logic [3:0] mask_in = 4'hF;
`endif

    logic [0:0] exp_q[$];
    logic       mon_en = 1'b0;
    logic       mon_e;
    logic       prev_e = 1'b0;
    int         n_total = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQDET_MASK_EN
        .mask_in(mask_in),
`endif
        .overlap_en(overlap_en), .cnt_clr(cnt_clr),
        .match(match), .match_q(match_q), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQDET_MASK_EN
        .mask_in(mask_in),
`endif
        .overlap_en(overlap_en), .cnt_clr(cnt_clr),
        .match(match2), .match_q(match_q2), .match_cnt(cnt2), .cnt_sat(sat2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every active beat pops one expectation; idle cycles must show no match.
    always @(negedge clk) begin
        if (mon_en) begin
            if (in_valid || pat_load) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL queue_underflow: got empty queue, expected an entry (t=%0t)", $time);
                    mon_e = 1'b0;
                end else begin
                    mon_e = exp_q.pop_front();
                end
                check("match", {31'b0, match}, {31'b0, mon_e});
            end else begin
                mon_e = 1'b0;
                check("idle_match", {31'b0, match}, 32'd0);
            end
            check("match_q", {31'b0, match_q}, {31'b0, prev_e});
            prev_e = mon_e;
        end
    end

    task automatic drive(input logic rn, input logic v, input logic b, input logic pl,
                         input logic cc, input logic [3:0] pi, input logic e);
        @(posedge clk);
        #1;
        rst_n    = rn;
        in_valid = v;
        in_bit   = b;
        pat_load = pl;
        cnt_clr  = cc;
        pat_in   = pi;
        if (v || pl) exp_q.push_back(e);
    endtask

    task automatic send(input logic b, input logic e);
        drive(1'b1, 1'b1, b, 1'b0, 1'b0, 4'b0, e);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    endtask

    task automatic restart(input logic [3:0] pat);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pat, 1'b0);
    endtask

    // Bits are sent MSB (index n-1) first; e marks the beats that must match.
    task automatic send_stream(input logic [31:0] s, input logic [31:0] e, input int n);
        for (int i = n - 1; i >= 0; i--) send(s[i], e[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        idle();
        mon_en = 1'b1;
        check("rst_cnt", {24'b0, match_cnt}, 32'd0);
        check("rst_sat", {31'b0, cnt_sat}, 32'd0);
        check("rst_match_q", {31'b0, match_q}, 32'd0);
        check("rst_cnt2", {30'b0, cnt2}, 32'd0);

        // Long stream, overlapping: matches on bits 6, 11, 14.
        overlap_en = 1'b1;
        restart(4'b1011);
        send_stream(32'b10101111011011, 32'b00000100001001, 14);
        idle();
        check("ovl_cnt", {24'b0, match_cnt}, 32'd3);

        // Same stream, non-overlapping: matches on bits 6 and 11.
        overlap_en = 1'b0;
        restart(4'b1011);
        send_stream(32'b10101111011011, 32'b00000100001000, 14);
        idle();
        check("novl_cnt", {24'b0, match_cnt}, 32'd2);

        // 1011011: overlap matches on bits 4 and 7, non-overlap only on bit 4.
        overlap_en = 1'b1;
        restart(4'b1011);
        send_stream(32'b1011011, 32'b0001001, 7);
        idle();
        check("short_ovl_cnt", {24'b0, match_cnt}, 32'd2);
        overlap_en = 1'b0;
        restart(4'b1011);
        send_stream(32'b1011011, 32'b0001000, 7);
        idle();
        check("short_novl_cnt", {24'b0, match_cnt}, 32'd1);

        // Pattern load mid-stream: load-cycle bit is dropped, count survives.
        overlap_en = 1'b1;
        restart(4'b1011);
        send_stream(32'b101110, 32'b000100, 6);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b0);
        idle();
        check("load_cnt_kept", {24'b0, match_cnt}, 32'd1);
        send_stream(32'b0110, 32'b0001, 4);
        idle();
        check("load_match_cnt", {24'b0, match_cnt}, 32'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0);
        send_stream(32'b1100110, 32'b0000001, 7);
        idle();
        check("load_discard_cnt", {24'b0, match_cnt}, 32'd3);

        // Saturation on the 2-bit counter, then clear together with a match.
        restart(4'b1011);
        send_stream(32'b1011, 32'b0001, 4);
        idle();
        check("sat_cnt_1", {30'b0, cnt2}, 32'd1);
        check("sat_flag_1", {31'b0, sat2}, 32'd0);
        send_stream(32'b011, 32'b001, 3);
        idle();
        check("sat_cnt_2", {30'b0, cnt2}, 32'd2);
        check("sat_flag_2", {31'b0, sat2}, 32'd0);
        send_stream(32'b011, 32'b001, 3);
        idle();
        check("sat_cnt_3", {30'b0, cnt2}, 32'd3);
        check("sat_flag_3", {31'b0, sat2}, 32'd1);
        send_stream(32'b011, 32'b001, 3);
        idle();
        check("sat_cnt_4", {30'b0, cnt2}, 32'd3);
        check("sat_flag_4", {31'b0, sat2}, 32'd1);
        check("wide_cnt_4", {24'b0, match_cnt}, 32'd4);
        send_stream(32'b01, 32'b00, 2);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0, 1'b1);
        idle();
        check("clr_match_cnt2", {30'b0, cnt2}, 32'd1);
        check("clr_match_cnt", {24'b0, match_cnt}, 32'd1);

        // Reset after 1,0,1: the would-be completing bit is masked, history is lost.
        send_stream(32'b101, 32'b000, 3);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
        send(1'b1, 1'b0);
        idle();
        check("mid_rst_cnt", {24'b0, match_cnt}, 32'd0);
        check("mid_rst_cnt2", {30'b0, cnt2}, 32'd0);

        // Invalid gaps inside 1,0,1,1 must not break the match.
        restart(4'b1011);
        send(1'b1, 1'b0);
        idle();
        send(1'b0, 1'b0);
        idle();
        idle();
        send(1'b1, 1'b0);
        idle();
        send(1'b1, 1'b1);
        idle();
        check("gap_cnt", {24'b0, match_cnt}, 32'd1);

        repeat (3) idle();
        check("queue_drain", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the team's fixed 1011 Mealy detector. Detects a runtime-loadable PATTERN_W-bit serial pattern on a single-bit stream with a valid qualifier.
- Selectable overlapping or non-overlapping detection.
- Provides a combinational (Mealy) match, a registered match, and a saturating match counter.
- Sits between serial line front-ends and the status/interrupt logic of the detector project.

Parameters:
- PATTERN_W, 4, pattern length in bits; legal range 2..32.
- PATTERN, 4'b1011, reset/default pattern; MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_bit is a new stream bit this cycle.
- in_bit  input  1  serial data bit.
- pat_load  input  1  load pat_in as the new pattern.
- pat_in  input  PATTERN_W  pattern value to load.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  clear the match counter.
- match  output  1  Mealy match, combinational from the current inputs and state.
- match_q  output  1  match registered one cycle later.
- match_cnt  output  CNT_W  saturating count of matches.
- cnt_sat  output  1  match_cnt is all-ones.

Behaviour:
- Reset (rst_n=0 at a clk edge): pattern reg=PATTERN, hist=0, fill=0, match_q=0, match_cnt=0. While rst_n=0, match=0.
- State:
  - hist: PATTERN_W-1 most recent accepted bits.
  - fill: count of accepted bits since the last restart, saturating at PATTERN_W-1.
- Accept: when in_valid=1 and pat_load=0:
  - hist shifts left, in_bit enters the LSB.
  - fill increments unless already saturated.
- in_valid=0: hist and fill hold; match=0.
- match = in_valid & ~pat_load & (fill==PATTERN_W-1) & ({hist,in_bit}==pattern). The zero-latency Mealy output is asserted in the same cycle as the final pattern bit.
- On match, overlap_en=1: hist shifts normally, fill stays saturated. The suffix can start the next match.
- On match, overlap_en=0: hist<=0, fill<=0. Restart; a new match needs PATTERN_W fresh bits.
- overlap_en is sampled per cycle. Changing it mid-stream only affects matches from that cycle on.
- match_q <= match every cycle; registered latency is 1.
- pat_load=1 has priority over in_valid:
  - pattern<=pat_in, hist<=0, fill<=0.
  - The in_bit that cycle is discarded and match=0.
  - match_cnt is unaffected.
- match_cnt:
  - Increments on match and saturates at 2^CNT_W-1; cnt_sat = &match_cnt.
  - cnt_clr=1 sets it to 0.
  - cnt_clr and match in the same cycle gives match_cnt=1.
  - Match while saturated: the count holds.
- Reset mid-pattern discards partial history. The first match after reset needs PATTERN_W bits.

Optional Feature:
- Macro: SEQDET_MASK_EN.
- Defined:
  - Adds input mask_in[PATTERN_W-1:0] and an internal mask reg, loaded alongside pat_in on pat_load.
  - Mask reset value is all-ones.
  - Compare becomes (({hist,in_bit} ^ pattern) & mask)==0; a mask bit of 0 is a don't-care.
- Undefined: the port and reg are absent and the compare is exact.

Decomposition:
- Package seq_det_pkg holds:
  - default pattern constant DEF_PATTERN=4'b1011.
  - FILL_W = $clog2(PATTERN_W) helper.
  - overlap mode enum {NON_OVERLAP=0, OVERLAP=1}.
- One sub-module, sat_counter (parameter W; ports inc, clr; outputs cnt, sat), is used for match_cnt.
- Shift/fill/compare logic stays in the top module.

Test Plan:
- Default pattern, overlap_en=1, stream 1,0,1,0,1,1,1,1,0,1,1,0,1,1 (one bit per cycle) -> match on bits 6, 11, 14; match_q one cycle after each; match_cnt=3.
- Same stream, overlap_en=0 -> match on bits 6 and 11 only; match_cnt=2.
- Stream 1,0,1,1,0,1,1 -> overlap: matches on bits 4 and 7; non-overlap: bit 4 only.
- pat_load with pat_in=4'b0110 mid-stream, then 0,1,1,0 -> in_bit discarded on the load cycle; match on the 4th bit after the load; count preserved across the load.
- CNT_W=2, 4 matches -> count 1,2,3,3 with cnt_sat=1 from the 3rd match; cnt_clr with a simultaneous match -> count=1.
- rst_n=0 after bits 1,0,1, then bit 1 -> no match; match_cnt=0. in_valid gaps inside 1,0,1,1 -> match still occurs on the 4th valid bit.
